ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_cfg_pkg.sv | 22 ++
 rtl/ccff_chain_loader.sv | 124 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccff_cfg_pkg
// Purpose  : Shared loader state type and default chain geometry.
// Revision : 1.0 - initial release
// ============================================================================
package ccff_cfg_pkg;

    localparam int c_DEFAULT_NUM_CHAINS = 10;
    localparam int c_DEFAULT_CHAIN_LEN  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } ccff_state_e;

endpackage : ccff_cfg_pkg
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Purpose  : Streams a bitstream into parallel CCFF chains, then verifies the
//            first word arrived at the chain tails.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader
    import ccff_cfg_pkg::*;
#(
    parameter  int NUM_CHAINS = c_DEFAULT_NUM_CHAINS,
    parameter  int CHAIN_LEN  = c_DEFAULT_CHAIN_LEN,
    localparam int CW         = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  prog_clock,
    input  logic                  global_reset_n,
    input  logic                  start,
    input  logic                  bs_valid,
    input  logic [NUM_CHAINS-1:0] bs_data,
    output logic                  bs_ready,
    output logic [NUM_CHAINS-1:0] ccff_head,
    output logic                  ccff_shift,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  config_enable,
    output logic                  CFG_DONE,
    output logic                  cfg_err,
    output logic [CW-1:0]         bit_count
);

    localparam logic [CW-1:0] c_LAST_IDX = CW'(CHAIN_LEN - 1);

    ccff_state_e           r_state;
    ccff_state_e           w_state_nxt;
    logic                  w_ready;
    logic                  w_cfg_en;
    logic                  w_done;
    logic                  w_err;
    logic                  w_restart;
    logic                  w_accept;

    logic [NUM_CHAINS-1:0] r_head;
    logic [NUM_CHAINS-1:0] r_word0;
    logic                  r_shift;
    logic [CW-1:0]         r_count;

    always_ff @(posedge prog_clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_cfg_en    = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                w_done = (r_state == ST_DONE);
                w_err  = (r_state == ST_ERROR);
                if (start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ready  = 1'b1;
                w_cfg_en = 1'b1;
                if (bs_valid && (r_count == c_LAST_IDX)) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // The last accepted word is still shifting in on this edge.
                w_cfg_en    = 1'b1;
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                w_cfg_en    = 1'b1;
                w_state_nxt = (ccff_tail == r_word0) ? ST_DONE : ST_ERROR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept = bs_valid & w_ready;

    always_ff @(posedge prog_clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_head  <= '0;
            r_word0 <= '0;
            r_shift <= 1'b0;
            r_count <= '0;
        end else begin
            // Shift only on accepted words so a valid gap stalls the chains.
            r_shift <= w_accept;
            if (w_restart) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_head  <= bs_data;
                r_count <= r_count + CW'(1);
                if (r_count == '0) begin
                    r_word0 <= bs_data;
                end
            end
        end
    end

    assign bs_ready      = w_ready;
    assign ccff_head     = r_head;
    assign ccff_shift    = r_shift;
    assign config_enable = w_cfg_en;
    assign CFG_DONE      = w_done;
    assign cfg_err       = w_err;
    assign bit_count     = r_count;

endmodule : ccff_chain_loader
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_chain_loader
// Purpose  : Self-checking bench: loader driving a 10x4 behavioural chain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int NC = 10;
    localparam int CL = 4;

    logic          prog_clock = 1'b0;
    logic          global_reset_n;
    logic          start;
    logic          bs_valid;
    logic [NC-1:0] bs_data;
    logic          bs_ready;
    logic [NC-1:0] ccff_head;
    logic          ccff_shift;
    logic [NC-1:0] ccff_tail;
    logic          config_enable;
    logic          CFG_DONE;
    logic          cfg_err;
    logic [2:0]    bit_count;

    logic [NC-1:0] chain [CL] = '{default: '0};
    logic [NC-1:0] stuck0 = '0;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [CL-1:0][NC-1:0] w;
        int                    gap_idx;
        int                    gap_len;
        logic [NC-1:0]         stuck;
        bit                    exp_done;
    } vec_t;

    vec_t tbl [4];

    ccff_chain_loader #(
        .NUM_CHAINS (NC),
        .CHAIN_LEN  (CL)
    ) u_dut (
        .prog_clock     (prog_clock),
        .global_reset_n (global_reset_n),
        .start          (start),
        .bs_valid       (bs_valid),
        .bs_data        (bs_data),
        .bs_ready       (bs_ready),
        .ccff_head      (ccff_head),
        .ccff_shift     (ccff_shift),
        .ccff_tail      (ccff_tail),
        .config_enable  (config_enable),
        .CFG_DONE       (CFG_DONE),
        .cfg_err        (cfg_err),
        .bit_count      (bit_count)
    );

    always #5 prog_clock = ~prog_clock;

    // Fabric: head -> FF0 .. FF3 -> tail, with optional stuck-at-0 tail bits.
    always @(posedge prog_clock) begin
        if (ccff_shift) begin
            chain[3] <= chain[2];
            chain[2] <= chain[1];
            chain[1] <= chain[0];
            chain[0] <= ccff_head;
        end
    end
    assign ccff_tail = chain[3] & ~stuck0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // The check passes exactly when no stuck-at-0 tail bit needs to carry a 1.
    function automatic bit ref_done(input logic [NC-1:0] w0, input logic [NC-1:0] stuck);
        return (w0 & stuck) == '0;
    endfunction

    task automatic start_pulse(input logic [NC-1:0] w0);
        start    = 1'b1;
        bs_valid = 1'b1;
        bs_data  = w0;
        @(negedge prog_clock);
        start = 1'b0;
        chk("start_cnt_clear", 32'(bit_count), 0);
        chk("start_cfg_en", 32'(config_enable), 1);
        chk("start_ready", 32'(bs_ready), 1);
        chk("start_done_clr", 32'(CFG_DONE), 0);
        chk("start_err_clr", 32'(cfg_err), 0);
        chk("start_no_shift", 32'(ccff_shift), 0);
    endtask

    task automatic feed(input logic [CL-1:0][NC-1:0] w, input int gap_idx, input int gap_len);
        for (int i = 0; i < CL; i++) begin
            if (i == gap_idx) begin
                bs_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge prog_clock);
                    chk("gap_shift", 32'(ccff_shift), 0);
                    chk("gap_cnt", 32'(bit_count), 32'(i));
                    if (i > 0) chk("gap_head_hold", 32'(ccff_head), 32'(w[i-1]));
                end
            end
            bs_valid = 1'b1;
            bs_data  = w[i];
            @(negedge prog_clock);
            chk("acc_head", 32'(ccff_head), 32'(w[i]));
            chk("acc_shift", 32'(ccff_shift), 1);
            chk("acc_cnt", 32'(bit_count), 32'(i + 1));
        end
        bs_valid = 1'b0;
    endtask

    task automatic finish_check(input logic [CL-1:0][NC-1:0] w, input bit exp_done);
        chk("settle_ready", 32'(bs_ready), 0);
        chk("settle_cfg_en", 32'(config_enable), 1);
        chk("settle_shift", 32'(ccff_shift), 1);
        @(negedge prog_clock);
        chk("check_shift", 32'(ccff_shift), 0);
        chk("check_cfg_en", 32'(config_enable), 1);
        chk("check_done", 32'(CFG_DONE), 0);
        @(negedge prog_clock);
        chk("end_done", 32'(CFG_DONE), 32'(exp_done));
        chk("end_err", 32'(cfg_err), 32'(!exp_done));
        chk("end_cfg_en", 32'(config_enable), 0);
        chk("end_cnt", 32'(bit_count), CL);
        for (int k = 0; k < CL; k++) begin
            chk("chain_ff", 32'(chain[k]), 32'(w[CL-1-k]));
        end
    endtask

    task automatic do_load(input logic [CL-1:0][NC-1:0] w, input int gap_idx,
                           input int gap_len, input bit exp_done);
        start_pulse(w[0]);
        feed(w, gap_idx, gap_len);
        finish_check(w, exp_done);
    endtask

    initial begin
        logic [CL-1:0][NC-1:0] w;
        int                    g;

        global_reset_n = 1'b0;
        start          = 1'b0;
        bs_valid       = 1'b0;
        bs_data        = '0;
        repeat (2) @(negedge prog_clock);
        chk("rst_ready", 32'(bs_ready), 0);
        chk("rst_head", 32'(ccff_head), 0);
        chk("rst_shift", 32'(ccff_shift), 0);
        chk("rst_cfg_en", 32'(config_enable), 0);
        chk("rst_done", 32'(CFG_DONE), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_cnt", 32'(bit_count), 0);
        global_reset_n = 1'b1;
        @(negedge prog_clock);
        chk("idle_ready", 32'(bs_ready), 0);

        tbl[0] = '{w: {10'h2AA, 10'h155, 10'h000, 10'h3FF}, gap_idx: -1, gap_len: 0,
                   stuck: 10'h000, exp_done: 1'b1};
        tbl[1] = '{w: {10'h2AA, 10'h155, 10'h000, 10'h3FF}, gap_idx: 2, gap_len: 3,
                   stuck: 10'h000, exp_done: 1'b1};
        tbl[2] = '{w: {10'h2AA, 10'h155, 10'h000, 10'h3FF}, gap_idx: -1, gap_len: 0,
                   stuck: 10'h020, exp_done: 1'b0};
        tbl[3] = '{w: {10'h3FF, 10'h000, 10'h2AA, 10'h155}, gap_idx: 0, gap_len: 2,
                   stuck: 10'h020, exp_done: 1'b1};
        for (int t = 0; t < 4; t++) begin
            stuck0 = tbl[t].stuck;
            do_load(tbl[t].w, tbl[t].gap_idx, tbl[t].gap_len, tbl[t].exp_done);
            stuck0 = '0;
            repeat (2) @(negedge prog_clock);
            chk("sticky_done", 32'(CFG_DONE), 32'(tbl[t].exp_done));
            chk("sticky_err", 32'(cfg_err), 32'(!tbl[t].exp_done));
        end

        // Reset in the middle of a load aborts it immediately.
        w = {10'h0F0, 10'h30F, 10'h1A5, 10'h0C3};
        start_pulse(w[0]);
        bs_data = w[0];
        @(negedge prog_clock);
        bs_data = w[1];
        @(negedge prog_clock);
        chk("pre_rst_cnt", 32'(bit_count), 2);
        #2 global_reset_n = 1'b0;
        #1;
        chk("arst_cfg_en", 32'(config_enable), 0);
        chk("arst_shift", 32'(ccff_shift), 0);
        chk("arst_head", 32'(ccff_head), 0);
        chk("arst_cnt", 32'(bit_count), 0);
        chk("arst_ready", 32'(bs_ready), 0);
        chk("arst_done", 32'(CFG_DONE), 0);
        chk("arst_err", 32'(cfg_err), 0);
        bs_valid = 1'b0;
        @(negedge prog_clock);
        global_reset_n = 1'b1;
        @(negedge prog_clock);
        chk("post_rst_idle", 32'(config_enable), 0);
        do_load(w, -1, 0, 1'b1);

        // Start during LOAD is ignored; start in DONE restarts.
        w = {10'h111, 10'h222, 10'h333, 10'h3C3};
        start_pulse(w[0]);
        bs_data = w[0];
        @(negedge prog_clock);
        bs_data = w[1];
        @(negedge prog_clock);
        bs_data = w[2];
        start   = 1'b1;
        @(negedge prog_clock);
        start = 1'b0;
        chk("load_start_cnt", 32'(bit_count), 3);
        chk("load_start_cfg_en", 32'(config_enable), 1);
        bs_data = w[3];
        @(negedge prog_clock);
        bs_valid = 1'b0;
        chk("load_start_cnt4", 32'(bit_count), 4);
        finish_check(w, 1'b1);
        do_load(w, 1, 1, 1'b1);

        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < CL; k++) w[k] = NC'($urandom);
            g      = int'($urandom_range(0, 4));
            stuck0 = ($urandom_range(0, 1) == 1) ? (NC'(1) << $urandom_range(0, NC - 1)) : '0;
            do_load(w, (g == 4) ? -1 : g, int'($urandom_range(1, 3)), ref_done(w[0], stuck0));
            stuck0 = '0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_ccff_chain_loader
`default_nettype wire
